// File: rtl/reg_scoreboard.sv
// Write-pending scoreboard between decode and writeback: tracks outstanding
// register writes per architectural register and stalls decode on hazards.
module reg_scoreboard #(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [2:0] rs_sel,
    input  logic       rs_used,
    input  logic [2:0] rt_sel,
    input  logic       rt_used,
    input  logic [2:0] rd_sel,
    input  logic       rd_write,
    input  logic       retire_valid,
    input  logic [2:0] retire_sel,
    output logic       stall,
    output logic       issue_fire,
    output logic [7:0] pending,
    output logic [2:0] inflight,
    output logic       err
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_INFLIGHT);

    logic [1:0] cnt      [8];
    logic [1:0] cnt_next [8];
    logic [2:0] inflight_next;

    logic raw;
    logic waw_sat;
    logic full;
    logic inc;
    logic ret_ok;
    logic underflow;

    // Hazards look only at registered counts so retire_* never reaches stall.
    always_comb begin
        raw        = (rs_used && (cnt[rs_sel] != 2'd0)) ||
                     (rt_used && (cnt[rt_sel] != 2'd0));
        waw_sat    = rd_write && (cnt[rd_sel] == 2'd3);
        full       = rd_write && (inflight == MAX_CNT);
        stall      = issue_valid && (raw || waw_sat || full);
        issue_fire = issue_valid && !stall;
        inc        = issue_fire && rd_write;
        ret_ok     = retire_valid && (cnt[retire_sel] != 2'd0);
        underflow  = retire_valid && (cnt[retire_sel] == 2'd0);
    end

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            cnt_next[i] = cnt[i];
            if (inc && (rd_sel == 3'(i)) && !(ret_ok && (retire_sel == 3'(i))))
                cnt_next[i] = cnt[i] + 2'd1;
            else if (ret_ok && (retire_sel == 3'(i)) && !(inc && (rd_sel == 3'(i))))
                cnt_next[i] = cnt[i] - 2'd1;
        end
    end

    always_comb begin
        inflight_next = inflight;
        if (inc && !ret_ok)
            inflight_next = inflight + 3'd1;
        else if (ret_ok && !inc)
            inflight_next = inflight - 3'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++)
                cnt[i] <= '0;
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < 8; i++)
                cnt[i] <= cnt_next[i];
            inflight <= inflight_next;
            if (underflow)
                err <= 1'b1;
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned i = 0; i < 8; i++)
            pending[i] = (cnt[i] != 2'd0);
    end

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Write-pending scoreboard that schedules instruction issue from the decode stage against the single-write-port register file. It tracks in-flight register writes per architectural register (R0–R7) and stalls decode on read-after-write hazards, per-register write saturation, or a full in-flight window. Writeback retires entries as the register file write completes. It sits between decode (issue side) and writeback (retire side), alongside the register file.

## Interface
Parameters:
- MAX_INFLIGHT, 4, total outstanding register writes allowed; legal range 1–7.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- issue_valid  input  1  decode presents an instruction this cycle.
- rs_sel  input  3  first source register (instruction[10:8]).
- rs_used  input  1  instruction reads rs_sel.
- rt_sel  input  3  second source register (instruction[7:5]).
- rt_used  input  1  instruction reads rt_sel.
- rd_sel  input  3  destination register after RegDst selection.
- rd_write  input  1  instruction writes rd_sel (RegWrite).
- retire_valid  input  1  writeback completes a write this cycle.
- retire_sel  input  3  register being written by writeback.
- stall  output  1  combinational; holds decode this cycle.
- issue_fire  output  1  combinational; issue_valid & ~stall.
- pending  output  8  registered; bit i = 1 when register i has ≥1 outstanding write.
- inflight  output  3  registered; total outstanding writes.
- err  output  1  registered, sticky retire-underflow flag.

## Operation
- State: eight 2-bit counters cnt[0..7], 3-bit inflight total, err flag.
- Hazard terms use registered state only. A same-cycle retire does not clear a hazard:
  - raw = (rs_used & cnt[rs_sel]≠0) | (rt_used & cnt[rt_sel]≠0).
  - waw_sat = rd_write & cnt[rd_sel]==3.
  - full = rd_write & inflight==MAX_INFLIGHT. A same-cycle retire does not relieve it.
- stall = issue_valid & (raw | waw_sat | full). stall = 0 whenever issue_valid = 0.
- inc = issue_fire & rd_write.
- ret_ok = retire_valid & cnt[retire_sel]≠0.
- Counter update at posedge:
  - cnt[rd_sel] += inc.
  - cnt[retire_sel] −= ret_ok.
  - If rd_sel==retire_sel with both inc and ret_ok, the count is unchanged.
- inflight_next = inflight + inc − ret_ok. It never exceeds MAX_INFLIGHT and never goes below 0.
- Underflow: retire_valid with cnt[retire_sel]==0 changes no counter and leaves inflight unchanged. err is set next edge and stays 1 until rst.
- Instructions with rd_write=0 (stores, branches, halt) issue whenever there is no raw hazard, regardless of full.
- pending[i] = (cnt[i]≠0), driven from registered state.

## Timing
- Reset (async, immediate on rst rising): all cnt = 0, inflight = 0, err = 0, pending = 8'h00. stall/issue_fire follow their combinational equations (stall = 0).
- Reset mid-operation discards all outstanding writes. Retires arriving after reset release count as underflow and set err.
- Issue latency: zero cycles; stall and issue_fire are valid in the same cycle as the inputs.
- Scoreboard effect of an issue is visible from the next cycle (pending/inflight update at the following edge).
- A retire in cycle N clears the hazard for an instruction presented in cycle N+1 at the earliest.
- No combinational path from retire_* to stall.
- Decode holds all issue inputs stable while stall = 1. The block keeps no memory of stalled requests.

## Test plan
- Reset then idle:
  - Stimulus: rst pulse mid-cycle.
  - Required: pending=00, inflight=0, err=0 immediately; stall=0 with issue_valid=0.
- RAW stall and release:
  - Stimulus: issue rd=3 write. Next cycle issue rs=3 used.
  - Required: stall=1. retire_sel=3 in cycle N keeps stall=1 in N. Stall=0 in N+1, pending=00.
- Window full (MAX_INFLIGHT=4):
  - Stimulus: issue writes to R1, R2, R4, R5. Fifth write to R6.
  - Required: stall=1 with inflight=4. A store (rd_write=0, no hazard) issues in the same state with stall=0.
  - Required: after one retire, R6 issues next cycle.
- WAW saturation:
  - Stimulus: three writes to R7 with no retires.
  - Required: pending=80, cnt=3. Fourth write to R7 stalls.
  - Required: simultaneous issue rd=7 and retire 7 after one retire keeps inflight constant.
- Underflow:
  - Stimulus: retire_sel=2 with pending=00.
  - Required: err=1 next cycle, inflight stays 0. err stays 1 until rst.
- Random issue/retire stream vs. reference model:
  - Required: inflight always equals the sum of the counters, never exceeds MAX_INFLIGHT, and no issue_fire occurs with a RAW hazard.
